countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Preset-loadable countdown timer: HH:MM:SS.t digits count down to 00:00:00.0 at one tenth-second per prescaler tick.
//  Raises a one-cycle done pulse and a latched alarm on expiry.
//  Same digit format as the stopwatch, so both share the display mux.
//  Sits beside the stopwatch in the clock/timer top; mode logic selects which digit set drives the display.
// PARAMETERS
//  TICK_DIV  100000  clk cycles per tenth-second tick (prescaler counts 0..TICK_DIV-1)
//  PRE_W     17      prescaler width; must satisfy 2**PRE_W >= TICK_DIV
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, asynchronous, active-high
//  run         in   1  level: count while high, pause while low
//  load        in   1  1-cycle pulse: latch set_* digits as new value
//  clear       in   1  1-cycle pulse: zero all digits, go IDLE
//  set_hour2   in   2  preset hour tens (0..2)
//  set_hour1   in   4  preset hour units (0..9; 0..3 when hour2=2)
//  set_min2    in   3  preset min tens (0..5)
//  set_min1    in   4  preset min units (0..9)
//  set_sec2    in   3  preset sec tens (0..5)
//  set_sec1    in   4  preset sec units (0..9)
//  set_point1  in   4  preset tenths (0..9)
//  hour2_q, hour1_q, min2_q, min1_q, sec2_q, sec1_q, point1_q  out  2/4/3/4/3/4/4  current BCD digits
//  running     out  1  high while state==RUN
//  done        out  1  1-cycle pulse, same cycle digits first read all-zero
//  alarm       out  1  level: high in EXPIRED
//  load_err    out  1  1-cycle pulse: load rejected (invalid preset)
// BEHAVIOUR
//  Reset: all digits 0, prescaler 0, state IDLE, running/done/alarm/load_err = 0.
//  States:
//   - IDLE: prescaler held at 0. Moves to RUN when run=1 and value!=0; run is ignored while value==0.
//   - RUN: prescaler increments each clk. At TICK_DIV-1 it wraps to 0 and issues a tick. run=0 -> PAUSE.
//   - PAUSE: prescaler holds its count (no reset). run=1 -> RUN and resumes from the held count.
//   - EXPIRED: entered on the tick that makes the value zero. Prescaler forced to 0; digits stay 0; alarm=1; run ignored.
//  Tick decrement is a borrow chain:
//   - point1 0->9 borrows sec1; sec1 0->9 borrows sec2; sec2 0->5 borrows min1.
//   - min1 0->9 borrows min2; min2 0->5 borrows hour1; hour1 0->9 borrows hour2.
//   - Example: 10:00:00.0 -> 09:59:59.9 in one tick.
//  Zero detection: the tick applied at 00:00:00.1 yields 0.
//   - Same edge: state<=EXPIRED, done<=1, alarm<=1.
//   - done drops next cycle. The value never wraps below zero.
//  Load: the preset is valid iff every digit is in range and hour<=23.
//   - Valid load, any state: digits<=preset, prescaler<=0, state<=IDLE, alarm<=0.
//   - Invalid load: load_err pulses 1 cycle; digits, prescaler and state are unchanged.
//   - Loading all-zero is valid: the block stays IDLE.
//  Latency: first tick arrives TICK_DIV cycles after entering RUN from IDLE. IDLE->RUN itself costs 1 cycle.
//  Priority on the same edge: clear > load > tick/run transitions. A tick coinciding with load/clear is discarded.
//  Clear: digits 0, prescaler 0, state IDLE, alarm 0; done/load_err not asserted.
//  rst mid-count: immediate return to reset values regardless of clk.
//  All digit arithmetic is per-digit BCD at the stated widths; no binary carry leaks between fields.
// TESTING (sim with TICK_DIV=4)
//  1. Assert rst mid-RUN at 00:05:00.0 -> all outputs 0 asynchronously, IDLE after release.
//  2. load 00:00:01.0, run=1 -> running=1 next cycle; 10 ticks (40 clk) later digits 0, done 1 cycle, alarm=1, running=0.
//  3. load 10:00:00.0, run=1, wait 1 tick -> 09:59:59.9; load 20:00:00.0 then 1 tick -> 19:59:59.9.
//  4. Mid-count (prescaler=2) drop run for 7 clk, then re-raise -> digits frozen; next tick after exactly 2 further RUN clk.
//  5. load sec2=6, then load 24:00:00.0 -> load_err pulse each; digits unchanged; valid load 23:59:59.9 accepted.
//  6. In EXPIRED assert clear and load on the same cycle -> digits 0, alarm 0, IDLE (clear wins); run=1 then ignored.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for the countdown timer: run/load/clear controls, preset digits in,
// current BCD digits and status flags out.
interface countdown_timer_if;
  logic       run;
  logic       load;
  logic       clear;
  logic [1:0] set_hour2;
  logic [3:0] set_hour1;
  logic [2:0] set_min2;
  logic [3:0] set_min1;
  logic [2:0] set_sec2;
  logic [3:0] set_sec1;
  logic [3:0] set_point1;
  logic [1:0] hour2_q;
  logic [3:0] hour1_q;
  logic [2:0] min2_q;
  logic [3:0] min1_q;
  logic [2:0] sec2_q;
  logic [3:0] sec1_q;
  logic [3:0] point1_q;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;

  modport master (
    output run, load, clear,
    output set_hour2, set_hour1, set_min2, set_min1, set_sec2, set_sec1, set_point1,
    input  hour2_q, hour1_q, min2_q, min1_q, sec2_q, sec1_q, point1_q,
    input  running, done, alarm, load_err
  );

  modport slave (
    input  run, load, clear,
    input  set_hour2, set_hour1, set_min2, set_min1, set_sec2, set_sec1, set_point1,
    output hour2_q, hour1_q, min2_q, min1_q, sec2_q, sec1_q, point1_q,
    output running, done, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// HH:MM:SS.t countdown timer: BCD borrow-chain decrement once per prescaler tick,
// one-cycle done pulse and latched alarm at zero, validated preset load.
module countdown_timer #(
  parameter int TICK_DIV = 100000,
  parameter int PRE_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       hour2_q, hour2_d;
  logic [3:0]       hour1_q, hour1_d;
  logic [2:0]       min2_q, min2_d;
  logic [3:0]       min1_q, min1_d;
  logic [2:0]       sec2_q, sec2_d;
  logic [3:0]       sec1_q, sec1_d;
  logic [3:0]       point1_q, point1_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             alarm_q, alarm_d;
  logic             load_err_q, load_err_d;

  // Returns {borrow_out, digit}; a digit at 0 wraps to its field maximum and borrows.
  function automatic logic [4:0] dec_bcd(input logic [3:0] d, input logic [3:0] top,
                                         input logic bin);
    if (!bin)
      return {1'b0, d};
    else if (d == 4'd0)
      return {1'b1, top};
    else
      return {1'b0, d - 4'd1};
  endfunction

  logic [4:0] dp1, ds1, ds2, dm1, dm2, dh1, dh2;
  logic       value_nz, dec_zero, preset_ok;

  always_comb begin
    dp1 = dec_bcd(point1_q, 4'd9, 1'b1);
    ds1 = dec_bcd(sec1_q, 4'd9, dp1[4]);
    ds2 = dec_bcd({1'b0, sec2_q}, 4'd5, ds1[4]);
    dm1 = dec_bcd(min1_q, 4'd9, ds2[4]);
    dm2 = dec_bcd({1'b0, min2_q}, 4'd5, dm1[4]);
    dh1 = dec_bcd(hour1_q, 4'd9, dm2[4]);
    dh2 = dec_bcd({2'b00, hour2_q}, 4'd0, dh1[4]);

    value_nz = (hour2_q != 2'd0) || (hour1_q != 4'd0) || (min2_q != 3'd0) ||
               (min1_q != 4'd0) || (sec2_q != 3'd0) || (sec1_q != 4'd0) ||
               (point1_q != 4'd0);
    dec_zero = (dh2[3:0] == 4'd0) && (dh1[3:0] == 4'd0) && (dm2[3:0] == 4'd0) &&
               (dm1[3:0] == 4'd0) && (ds2[3:0] == 4'd0) && (ds1[3:0] == 4'd0) &&
               (dp1[3:0] == 4'd0);
    preset_ok = (bus.set_hour2 <= 2'd2) && (bus.set_hour1 <= 4'd9) &&
                !((bus.set_hour2 == 2'd2) && (bus.set_hour1 > 4'd3)) &&
                (bus.set_min2 <= 3'd5) && (bus.set_min1 <= 4'd9) &&
                (bus.set_sec2 <= 3'd5) && (bus.set_sec1 <= 4'd9) &&
                (bus.set_point1 <= 4'd9);
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    hour2_d    = hour2_q;
    hour1_d    = hour1_q;
    min2_d     = min2_q;
    min1_d     = min1_q;
    sec2_d     = sec2_q;
    sec1_d     = sec1_q;
    point1_d   = point1_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;

    if (bus.clear) begin
      {hour2_d, hour1_d, min2_d, min1_d, sec2_d, sec1_d, point1_d} = '0;
      pre_d   = '0;
      state_d = S_IDLE;
    end else if (bus.load) begin
      if (preset_ok) begin
        hour2_d  = bus.set_hour2;
        hour1_d  = bus.set_hour1;
        min2_d   = bus.set_min2;
        min1_d   = bus.set_min1;
        sec2_d   = bus.set_sec2;
        sec1_d   = bus.set_sec1;
        point1_d = bus.set_point1;
        pre_d    = '0;
        state_d  = S_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          pre_d = '0;
          if (bus.run && value_nz) state_d = S_RUN;
        end
        S_RUN: begin
          // Dropping run freezes the prescaler on that edge so the resume picks up exactly.
          if (!bus.run) begin
            state_d = S_PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d    = '0;
            hour2_d  = dh2[1:0];
            hour1_d  = dh1[3:0];
            min2_d   = dm2[2:0];
            min1_d   = dm1[3:0];
            sec2_d   = ds2[2:0];
            sec1_d   = ds1[3:0];
            point1_d = dp1[3:0];
            if (dec_zero) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        S_PAUSE: begin
          if (bus.run) state_d = S_RUN;
        end
        default: begin
          pre_d = '0;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      hour2_q    <= '0;
      hour1_q    <= '0;
      min2_q     <= '0;
      min1_q     <= '0;
      sec2_q     <= '0;
      sec1_q     <= '0;
      point1_q   <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      hour2_q    <= hour2_d;
      hour1_q    <= hour1_d;
      min2_q     <= min2_d;
      min1_q     <= min1_d;
      sec2_q     <= sec2_d;
      sec1_q     <= sec1_d;
      point1_q   <= point1_d;
      running_q  <= running_d;
      done_q     <= done_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.hour2_q  = hour2_q;
  assign bus.hour1_q  = hour1_q;
  assign bus.min2_q   = min2_q;
  assign bus.min1_q   = min1_q;
  assign bus.sec2_q   = sec2_q;
  assign bus.sec1_q   = sec1_q;
  assign bus.point1_q = point1_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at TICK_DIV=4; expectations are queued on a scoreboard
// as stimulus is applied and popped against the DUT outputs at each sample point.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst;

  countdown_timer_if bus ();

  countdown_timer #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] dig(input int h2, h1, m2, m1, s2, s1, p1);
    return {8'h00, 2'(h2), 4'(h1), 3'(m2), 4'(m1), 3'(s2), 4'(s1), 4'(p1)};
  endfunction

  function automatic logic [31:0] obs_dig();
    return {8'h00, bus.hour2_q, bus.hour1_q, bus.min2_q, bus.min1_q,
            bus.sec2_q, bus.sec1_q, bus.point1_q};
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    push(tag, exp);
    chk(obs);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input int h2, h1, m2, m1, s2, s1, p1);
    bus.set_hour2  = 2'(h2);
    bus.set_hour1  = 4'(h1);
    bus.set_min2   = 3'(m2);
    bus.set_min1   = 4'(m1);
    bus.set_sec2   = 3'(s2);
    bus.set_sec1   = 4'(s1);
    bus.set_point1 = 4'(p1);
  endtask

  task automatic do_load(input int h2, h1, m2, m1, s2, s1, p1);
    set_preset(h2, h1, m2, m1, s2, s1, p1);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.run   = 1'b0;
    bus.load  = 1'b0;
    bus.clear = 1'b0;
    set_preset(0, 0, 0, 0, 0, 0, 0);
    step(2);
    expect_eq("reset_digits",   dig(0, 0, 0, 0, 0, 0, 0), obs_dig());
    expect_eq("reset_running",  0, 32'(bus.running));
    expect_eq("reset_done",     0, 32'(bus.done));
    expect_eq("reset_alarm",    0, 32'(bus.alarm));
    expect_eq("reset_load_err", 0, 32'(bus.load_err));
    rst = 1'b0;
    step(1);

    // Asynchronous reset in the middle of a run.
    do_load(0, 0, 0, 5, 0, 0, 0);
    bus.run = 1'b1;
    step(6);
    expect_eq("t1_first_tick", dig(0, 0, 0, 4, 5, 9, 9), obs_dig());
    expect_eq("t1_running", 1, 32'(bus.running));
    rst = 1'b1;
    #2;
    expect_eq("t1_async_digits",  dig(0, 0, 0, 0, 0, 0, 0), obs_dig());
    expect_eq("t1_async_running", 0, 32'(bus.running));
    step(1);
    rst = 1'b0;
    step(2);
    expect_eq("t1_idle_after_rst", 0, 32'(bus.running));
    bus.run = 1'b0;

    // Run 1.0 s down to zero.
    do_load(0, 0, 0, 0, 0, 1, 0);
    bus.run = 1'b1;
    step(1);
    expect_eq("t2_running_next", 1, 32'(bus.running));
    step(39);
    expect_eq("t2_last_tenth", dig(0, 0, 0, 0, 0, 0, 1), obs_dig());
    expect_eq("t2_done_early", 0, 32'(bus.done));
    step(1);
    expect_eq("t2_zero",        dig(0, 0, 0, 0, 0, 0, 0), obs_dig());
    expect_eq("t2_done",        1, 32'(bus.done));
    expect_eq("t2_alarm",       1, 32'(bus.alarm));
    expect_eq("t2_running_off", 0, 32'(bus.running));
    step(1);
    expect_eq("t2_done_drop",   0, 32'(bus.done));
    expect_eq("t2_alarm_held",  1, 32'(bus.alarm));
    expect_eq("t2_no_wrap",     dig(0, 0, 0, 0, 0, 0, 0), obs_dig());

    // Clear and load together while expired: clear wins.
    set_preset(1, 2, 3, 4, 5, 6, 7);
    bus.clear = 1'b1;
    bus.load  = 1'b1;
    step(1);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    expect_eq("t6_digits",   dig(0, 0, 0, 0, 0, 0, 0), obs_dig());
    expect_eq("t6_alarm",    0, 32'(bus.alarm));
    expect_eq("t6_running",  0, 32'(bus.running));
    expect_eq("t6_load_err", 0, 32'(bus.load_err));
    step(3);
    expect_eq("t6_run_ignored", 0, 32'(bus.running));
    bus.run = 1'b0;

    // Full borrow chain through the hour digits.
    do_load(1, 0, 0, 0, 0, 0, 0);
    bus.run = 1'b1;
    step(5);
    expect_eq("t3_borrow_10h", dig(0, 9, 5, 9, 5, 9, 9), obs_dig());
    do_load(2, 0, 0, 0, 0, 0, 0);
    expect_eq("t3_load_to_idle", 0, 32'(bus.running));
    step(5);
    expect_eq("t3_borrow_20h", dig(1, 9, 5, 9, 5, 9, 9), obs_dig());

    // Pause with the prescaler at 2, then resume.
    step(2);
    bus.run = 1'b0;
    step(1);
    expect_eq("t4_paused", 0, 32'(bus.running));
    step(6);
    expect_eq("t4_frozen", dig(1, 9, 5, 9, 5, 9, 9), obs_dig());
    bus.run = 1'b1;
    step(1);
    expect_eq("t4_resumed", 1, 32'(bus.running));
    step(1);
    expect_eq("t4_no_tick_yet", dig(1, 9, 5, 9, 5, 9, 9), obs_dig());
    step(1);
    expect_eq("t4_tick", dig(1, 9, 5, 9, 5, 9, 8), obs_dig());

    // Invalid presets rejected, valid maximum accepted.
    bus.run = 1'b0;
    step(1);
    do_load(0, 0, 0, 0, 6, 0, 0);
    expect_eq("t5_err_sec2",    1, 32'(bus.load_err));
    expect_eq("t5_keep_sec2",   dig(1, 9, 5, 9, 5, 9, 8), obs_dig());
    step(1);
    expect_eq("t5_err_pulse",   0, 32'(bus.load_err));
    do_load(2, 4, 0, 0, 0, 0, 0);
    expect_eq("t5_err_hour24",  1, 32'(bus.load_err));
    expect_eq("t5_keep_hour24", dig(1, 9, 5, 9, 5, 9, 8), obs_dig());
    do_load(2, 3, 5, 9, 5, 9, 9);
    expect_eq("t5_ok_err",      0, 32'(bus.load_err));
    expect_eq("t5_ok_digits",   dig(2, 3, 5, 9, 5, 9, 9), obs_dig());

    // All-zero load is valid and stays idle with run high.
    do_load(0, 0, 0, 0, 0, 0, 0);
    bus.run = 1'b1;
    step(2);
    expect_eq("zero_load_err",  0, 32'(bus.load_err));
    expect_eq("zero_load_idle", 0, 32'(bus.running));
    bus.run = 1'b0;

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
